// File: rtl/servo_cap_pkg.sv
// Shared constants and types for the servo pulse capture block.
// Holds the default legal pulse range (in 12 MHz cycles), the cycles-per-ms
// constant, the frame timeout default and the capture FSM state encoding.
package servo_cap_pkg;

  localparam int unsigned CYC_PER_MS    = 12000;
  localparam int unsigned W_DEF         = 15;
  localparam int unsigned MIN_ON_DEF    = 6000;
  localparam int unsigned MAX_ON_DEF    = 24000;
  localparam int unsigned FW_DEF        = 19;
  localparam int unsigned FRAME_MAX_DEF = 300000;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    LOW      = 2'd1,
    HIGH     = 2'd2
  } cap_state_e;

endpackage

// File: rtl/servo_cap_if.sv
// Bundle of the servo capture signals.
//   srv_i : asynchronous PWM input into the capture block
//   on_t  : last valid pulse width in clk cycles
//   vld   : one-cycle strobe when on_t updates
//   err   : one-cycle strobe on an out-of-range pulse
//   los   : loss-of-signal level
// master = the capture block, slave = its environment.
interface servo_cap_if #(
  parameter int unsigned W = 15
) ();
  logic         srv_i;
  logic [W-1:0] on_t;
  logic         vld;
  logic         err;
  logic         los;

  modport master (input srv_i, output on_t, output vld, output err, output los);
  modport slave  (output srv_i, input on_t, input vld, input err, input los);
endinterface

// File: rtl/servo_cap_sync_edge.sv
// Two-flop synchronizer with rise/fall detect for an asynchronous input.
//   clk, rst_n : clock, async active-low reset
//   d          : asynchronous input
//   q          : synchronized level (s2)
//   rise_c     : s2 & ~s3 (combinational)
//   fall_c     : ~s2 & s3 (combinational)
//   ready      : high once q reflects a real sample rather than reset state
module servo_cap_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c,
  output logic ready
);

  logic s1, s2, s3;
  logic p1, p2;

  // Synchronizer, delayed copy and a matching priming pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      p1 <= 1'b0;
      p2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
      p1 <= 1'b1;
      p2 <= p1;
    end
  end

  assign q      = s2;
  assign rise_c = s2 & ~s3;
  assign fall_c = ~s2 & s3;
  assign ready  = p2;

endmodule

// File: rtl/servo_cap.sv
// Servo pulse capture: measures the high time of a hobby-servo PWM input in
// clk cycles, range-checks it, and detects loss of signal.
//   clk, rst_n : clock, async active-low reset
//   bus        : servo_cap_if master (srv_i in; on_t, vld, err, los out)
module servo_cap
  import servo_cap_pkg::*;
#(
  parameter int unsigned W         = W_DEF,
  parameter int unsigned MIN_ON    = MIN_ON_DEF,
  parameter int unsigned MAX_ON    = MAX_ON_DEF,
  parameter int unsigned FW        = FW_DEF,
  parameter int unsigned FRAME_MAX = FRAME_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  servo_cap_if.master   bus
);

  localparam logic [W-1:0]  MIN_C  = W'(MIN_ON);
  localparam logic [W-1:0]  OVER_C = W'(MAX_ON + 1);
  localparam logic [FW-1:0] FMAX_C = FW'(FRAME_MAX);

  logic s2, rise_c, fall_c, ready;

  cap_state_e   state, state_nxt;
  logic [W-1:0] cnt, cnt_nxt;
  logic [W-1:0] on_t_q, on_t_nxt;
  logic         vld_q, vld_nxt;
  logic         err_q, err_nxt;
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic         los_q, los_nxt;

  servo_cap_sync_edge u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (bus.srv_i),
    .q      (s2),
    .rise_c (rise_c),
    .fall_c (fall_c),
    .ready  (ready)
  );

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= WAIT_LOW;
      cnt    <= '0;
      on_t_q <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
      fcnt   <= '0;
      los_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      on_t_q <= on_t_nxt;
      vld_q  <= vld_nxt;
      err_q  <= err_nxt;
      fcnt   <= fcnt_nxt;
      los_q  <= los_nxt;
    end
  end

  // Pulse FSM and width counter; frame timeout follows the vld decision.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    on_t_nxt  = on_t_q;
    vld_nxt   = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      // ready gates out the reset value of s2 so an in-progress pulse is skipped.
      WAIT_LOW: if (ready && !s2) state_nxt = LOW;
      // The rise cycle already has s2 high, so it is counted as the first sample.
      LOW: if (rise_c) begin
        cnt_nxt   = W'(1);
        state_nxt = HIGH;
      end
      HIGH: begin
        if (cnt == OVER_C) begin
          err_nxt   = 1'b1;
          state_nxt = WAIT_LOW;
        end else if (fall_c) begin
          if (cnt < MIN_C) begin
            err_nxt = 1'b1;
          end else begin
            on_t_nxt = cnt;
            vld_nxt  = 1'b1;
          end
          state_nxt = LOW;
        end else if (s2) begin
          cnt_nxt = cnt + W'(1);
        end
      end
      default: state_nxt = WAIT_LOW;
    endcase

    if (vld_nxt)               fcnt_nxt = '0;
    else if (fcnt >= FMAX_C)   fcnt_nxt = fcnt;
    else                       fcnt_nxt = fcnt + FW'(1);

    los_nxt = !vld_nxt && (fcnt_nxt >= FMAX_C);
  end

  assign bus.on_t = on_t_q;
  assign bus.vld  = vld_q;
  assign bus.err  = err_q;
  assign bus.los  = los_q;

endmodule

// File: tb/tb_servo_cap.sv
// Bench for servo_cap: directed and random pulse trains compared every cycle
// against a sample-level reference model of the capture rules.
module tb_servo_cap;

  localparam int unsigned W         = 15;
  localparam int unsigned MIN_ON    = 60;
  localparam int unsigned MAX_ON    = 240;
  localparam int unsigned FW        = 19;
  localparam int unsigned FRAME_MAX = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  servo_cap_if #(.W(W)) bus ();

  servo_cap #(
    .W(W), .MIN_ON(MIN_ON), .MAX_ON(MAX_ON), .FW(FW), .FRAME_MAX(FRAME_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state: sample index since reset and pending output events.
  int   edge_n;
  bit   armed, meas;
  int   run;
  int   since;
  int   m_on_t;
  int   ev_edge[$];
  int   ev_kind[$];   // 0 = vld, 1 = err
  int   ev_val[$];
  int   dut_err_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s at sample %0d: observed=%0d expected=%0d", tag, edge_n, obs, exp);
    end
  endtask

  task automatic model_reset();
    edge_n = 0; armed = 1'b0; meas = 1'b0; run = 0; since = 0; m_on_t = 0;
    ev_edge.delete(); ev_kind.delete(); ev_val.delete();
  endtask

  task automatic push_ev(input int e, input int k, input int v);
    ev_edge.push_back(e); ev_kind.push_back(k); ev_val.push_back(v);
  endtask

  // One sampling edge with srv_i = x, then compare all outputs.
  task automatic step(input logic x);
    bit exp_vld, exp_err, exp_los;
    bus.srv_i = x;
    @(posedge clk);
    edge_n++;
    // Pulse measurement on raw samples: outputs appear 2 samples after the
    // first low sample, or 3 samples after the (MAX_ON+1)-th high sample.
    if (meas) begin
      if (x) begin
        run++;
        if (run == int'(MAX_ON) + 1) begin
          push_ev(edge_n + 3, 1, 0);
          meas = 1'b0;
          armed = 1'b0;
        end
      end else begin
        if (run >= int'(MIN_ON)) push_ev(edge_n + 2, 0, run);
        else                     push_ev(edge_n + 2, 1, 0);
        meas = 1'b0;
      end
    end else if (!armed) begin
      if (!x) armed = 1'b1;
    end else if (x) begin
      meas = 1'b1;
      run = 1;
    end
    exp_vld = 1'b0;
    exp_err = 1'b0;
    if (ev_edge.size() > 0 && ev_edge[0] == edge_n) begin
      if (ev_kind[0] == 0) begin
        exp_vld = 1'b1;
        m_on_t = ev_val[0];
      end else begin
        exp_err = 1'b1;
      end
      void'(ev_edge.pop_front()); void'(ev_kind.pop_front()); void'(ev_val.pop_front());
    end
    if (exp_vld) since = 0;
    else         since++;
    exp_los = (since >= int'(FRAME_MAX));
    #1;
    if (bus.err) dut_err_cnt++;
    check("vld", 32'(bus.vld), 32'(exp_vld));
    check("err", 32'(bus.err), 32'(exp_err));
    check("on_t", 32'(bus.on_t), 32'(m_on_t));
    check("los", 32'(bus.los), 32'(exp_los));
  endtask

  task automatic pulse(input int hi, input int lo);
    repeat (hi) step(1'b1);
    repeat (lo) step(1'b0);
  endtask

  // Assert reset for n edges; outputs must clear immediately and stay clear.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    check("rst_vld", 32'(bus.vld), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_on_t", 32'(bus.on_t), 32'd0);
    check("rst_los", 32'(bus.los), 32'd0);
    repeat (n) @(posedge clk);
    #1;
    check("rst_hold_on_t", 32'(bus.on_t), 32'd0);
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    int w, lo, e0;
    bus.srv_i = 1'b0;
    dut_err_cnt = 0;
    model_reset();
    #2;
    do_reset(3);

    // Basic legal pulse after a quiet period.
    repeat (100) step(1'b0);
    pulse(120, 20);

    // Range boundaries.
    pulse(int'(MIN_ON), 20);
    pulse(int'(MAX_ON), 20);
    pulse(int'(MIN_ON) - 1, 20);
    pulse(int'(MAX_ON) + 1, 20);

    // Driver-like sweep with a fixed frame period.
    for (int i = 0; i <= 9; i++) begin
      w = int'(MIN_ON) + 20 * i;
      pulse(w, 300 - w);
    end

    // Random widths across and beyond the legal range, short gaps.
    for (int i = 0; i < 25; i++) begin
      w = int'($urandom_range(1, MAX_ON + 20));
      lo = int'($urandom_range(2, 40));
      pulse(w, lo);
    end

    // Reset in the middle of a pulse; the tail must be ignored.
    repeat (50) step(1'b1);
    do_reset(4);
    e0 = dut_err_cnt;
    repeat (100) step(1'b1);
    repeat (20) step(1'b0);
    check("midrst_no_err", 32'(dut_err_cnt - e0), 32'd0);
    pulse(150, 20);

    // Loss of signal, then recovery on a legal pulse.
    repeat (FRAME_MAX + 100) step(1'b0);
    pulse(65, 20);

    // Stuck high: a single err, los later, then normal recovery.
    e0 = dut_err_cnt;
    repeat (FRAME_MAX + 500) step(1'b1);
    check("stuck_err_count", 32'(dut_err_cnt - e0), 32'd1);
    repeat (20) step(1'b0);
    pulse(100, 20);

    check("pending_events", 32'(ev_edge.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/servo_cap.md
# servo_cap

Servo pulse capture: measures the high time of an incoming hobby-servo PWM signal and reports it in `clk` cycles, in the same `on_t` units that `servo_drv` consumes. A decoded pulse can be forwarded directly to a driver, which lets the design pass through or monitor an RC receiver channel. Each pulse is range-checked, malformed pulses are flagged, and loss of signal is detected.

## Interface
- `W`, 15: width of `on_t`; equals the `servo_drv` `on_t` width.
- `MIN_ON`, 15'h1770 (6000, 0.5 ms at 12 MHz): shortest legal pulse in cycles.
- `MAX_ON`, 15'h5dc0 (24000, 2.0 ms): longest legal pulse; must be < 2^W − 1.
- `FW`, 19: frame-timeout counter width.
- `FRAME_MAX`, 300000 (25 ms): cycles without a valid pulse before `los` asserts; must be < 2^FW.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `srv_i` in 1: asynchronous servo PWM input.
- `on_t` out W: last valid pulse width in cycles; reset 0.
- `vld` out 1: one-cycle strobe when `on_t` updates; reset 0.
- `err` out 1: one-cycle strobe on an out-of-range pulse; reset 0.
- `los` out 1: level, loss of signal; reset 0.

## Operation
- Input path: 2-FF synchronizer (s1, s2), plus a delayed copy s3. Rise = s2 & ~s3. Fall = ~s2 & s3. Synchronizer flops reset to 0.
- FSM states: WAIT_LOW, LOW, HIGH. Reset state is WAIT_LOW.
  - WAIT_LOW: go to LOW when s2 = 0. This ensures a pulse already in progress at reset or after an error is never measured.
  - LOW: on rise, clear the width counter and go to HIGH.
  - HIGH: the width counter increments on every cycle with s2 = 1.
    - On fall with width N in [MIN_ON, MAX_ON]: `on_t` <= N, pulse `vld`, go to LOW.
    - On fall with N < MIN_ON: pulse `err`; `on_t` is unchanged; go to LOW.
    - When the counter reaches MAX_ON + 1 while still high: pulse `err` immediately and go to WAIT_LOW. No second `err` is raised for the same pulse.
- Width counter: W bits. Its value never exceeds MAX_ON + 1, so it cannot wrap.
- Frame counter: FW bits, saturating.
  - Cleared on `vld`, otherwise increments every cycle.
  - `los` = (frame counter ≥ FRAME_MAX), registered. Once set, it clears only in the cycle `vld` pulses, i.e. the first valid pulse after the dropout.
  - Invalid pulses do not clear `los`.
- If `vld` and the frame counter would reach FRAME_MAX in the same cycle, `vld` wins: the counter clears and `los` stays 0.
- Reset mid-pulse: all outputs return to their reset values and the FSM returns to WAIT_LOW. The interrupted pulse is discarded without `err`.

## Timing
- `srv_i` high for exactly N sampling edges (rises before edge k, falls before edge k+N): the measured width is N.
- `vld` and `err` (short-pulse case) assert in the cycle after edge k+N+2. `on_t` holds the new value from that same cycle.
- The over-long `err` asserts 3 cycles after the (MAX_ON+1)-th high sample.
- `on_t` is stable between `vld` strobes. `vld` and `err` are never high together.
- Minimum low time between pulses: 2 cycles. Shorter glitches may be merged into one pulse.

## Structure
- `servo_defs.vh` holds the shared constants: MIN_ON/MAX_ON defaults (also used by `servo_drv` users), the 12 MHz cycles-per-ms constant, and the FSM state encodings.
- Sub-module `sync_edge`: 2-FF synchronizer plus rise/fall detect, with async active-low reset. It is reusable for other async inputs.
- The rest is a single module: FSM, width counter, frame counter, output registers.

## Test plan
- Legal pulse: after reset hold `srv_i` low 100 cycles, then high 12000 cycles → single `vld`, `on_t` = 12000, `err` = 0, latency as specified.
- Boundaries: pulses of 6000, 24000, 5999, 24001 cycles.
  - 6000 and 24000 → `vld` with those values.
  - 5999 → `err` at fall, `on_t` unchanged.
  - 24001 → `err` while still high, nothing at the later fall.
- Loop-back: feed the `servo_drv` output, with `on_t` swept 6000→24000, into `servo_cap` → each `vld` value equals the driven `on_t` ± 0.
- Reset mid-operation: `srv_i` high at `rst_n` deassertion, staying high 10000 more cycles → no `vld` or `err`. The next full 15000-cycle pulse → `vld`, 15000.
- Loss of signal: with FRAME_MAX = 1000 and `srv_i` held low → `los` = 1 after 1000 cycles. A following 6500-cycle pulse → `vld` and `los` = 0 in the same cycle.
- Stuck high: `srv_i` high indefinitely → exactly one `err`, then `los` rises at FRAME_MAX. `srv_i` then goes low followed by a legal pulse → normal `vld`.
